moore_seq_detector: RTL and testbench
=====================================

Name: moore_seq_detector

Overview:
Parametrised, runtime-programmable Moore sequence detector for a serial bit stream. It generalises the fixed "10" detector to any pattern of 1..MAX_LEN bits, selectable overlap/non-overlap matching, an input-valid qualifier and a saturating match counter. It sits on the serial input path and drives a registered one-cycle match flag to downstream control logic.

Parameters:
MAX_LEN, 8, maximum pattern length in bits (>=2)
CNT_W, 16, match counter width
LEN_W, $clog2(MAX_LEN)+1, width of cfg_len (derived; do not override)

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  asynchronous reset, active-high
cfg_load  input  1  load pattern configuration this cycle
cfg_pattern  input  MAX_LEN  pattern; bit [L-1] is the first bit received, bit [0] the last
cfg_len  input  LEN_W  pattern length L, legal range 1..MAX_LEN
cfg_overlap  input  1  1 = overlapping matches allowed, 0 = non-overlapping
in_valid  input  1  qualifies in
in  input  1  serial data bit
cnt_clr  input  1  synchronous clear of match_count
out  output  1  match flag, high only in state MATCH (Moore)
match_count  output  CNT_W  number of matches, saturating
state  output  2  current state: 00 UNCFG, 01 SEARCH, 10 MATCH
cfg_err  output  1  one-cycle pulse: cfg_load with illegal cfg_len

Behaviour:
- Reset (async, rst=1): state=UNCFG, out=0, match_count=0, cfg_err=0, stored pattern=0, stored L=1, overlap=0, history=0, fill=0.
- UNCFG: in_valid/in ignored; leaves only on a legal cfg_load.
- cfg_load with 1<=cfg_len<=MAX_LEN, in any state: latch pattern, L, overlap; clear history and fill; next state SEARCH. Same-cycle in_valid bit is discarded. match_count is not affected.
- cfg_load with cfg_len=0 or >MAX_LEN: configuration and state unchanged; cfg_err=1 for the next cycle only.
- Accepted bit (in_valid=1, no cfg_load, state SEARCH or MATCH): hist <= {hist[MAX_LEN-2:0], in}; fill <= min(fill+1, L).
- Match condition on an accepted bit: (fill+1 >= L) and hist_next[L-1:0] == pattern[L-1:0]; only the low L bits are compared.
- Transitions from SEARCH or MATCH:
  - accepted bit with match -> MATCH;
  - any other case -> SEARCH.
  - MATCH therefore lasts exactly one cycle per matching bit; back-to-back matches keep out high on consecutive cycles.
- Latency: bit accepted at edge k -> out=1 during the cycle after edge k; out is purely a decode of registered state.
- Non-overlap (overlap=0): on a match, fill is cleared to 0, so the next match needs L fresh accepted bits. Overlap (overlap=1): fill is kept at L.
- in_valid=0 cycles: history and fill are held; a gap never breaks a partial match.
- match_count: +1 on every transition into MATCH (including MATCH->MATCH); saturates at 2^CNT_W-1 with no wrap. cnt_clr has priority over a same-cycle increment (result 0).
- cfg_err: 0 except for the single pulse cycle.
- Reset asserted mid-operation: immediate return to UNCFG; out falls asynchronously; reconfiguration is required.

Test Plan:
- L=2, pattern=2'b10, overlap=1; stream 1,1,0,0,1,0 -> out high one cycle after the 3rd and 6th bits; match_count=2; state sequence returns to SEARCH after each match.
- L=2, pattern=2'b11; stream 1,1,1,1 -> overlap=1: out high after bits 2,3,4 (three consecutive cycles), count=3; overlap=0: out high after bits 2,4, count=2.
- L=4, pattern=4'b1011, in_valid deasserted for 3 cycles between bits 2 and 3 -> single match after the 4th accepted bit; out low during the gap.
- cfg_len=0, then cfg_len=MAX_LEN+1 -> cfg_err pulses once each; state and stored pattern unchanged; UNCFG ignores all stream bits.
- CNT_W=2, L=1, pattern=1, stream of 6 ones -> count 1,2,3,3,3,3; cnt_clr coinciding with a match -> count 0.
- rst asserted while state=MATCH -> out=0 and count=0 immediately; following stream bits are ignored until cfg_load.

Source files
------------

// File: rtl/moore_seq_detector.sv
// Runtime-programmable Moore sequence detector for a serial bit stream.
// It supports overlapping or non-overlapping matching, an input-valid qualifier and a saturating match counter.
module moore_seq_detector #(
  parameter int MAX_LEN = 8,
  parameter int CNT_W   = 16,
  parameter int LEN_W   = $clog2(MAX_LEN) + 1
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               cfg_load_i,
  input  logic [MAX_LEN-1:0] cfg_pattern_i,
  input  logic [LEN_W-1:0]   cfg_len_i,
  input  logic               cfg_overlap_i,
  input  logic               in_valid_i,
  input  logic               in_i,
  input  logic               cnt_clr_i,
  output logic               out_o,
  output logic [CNT_W-1:0]   match_count_o,
  output logic [1:0]         state_o,
  output logic               cfg_err_o
);

  typedef enum logic [1:0] {
    UNCFG  = 2'b00,
    SEARCH = 2'b01,
    MATCH  = 2'b10
  } state_e;

  state_e             state_q, state_d;
  logic [MAX_LEN-1:0] pattern_q, pattern_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic               overlap_q, overlap_d;
  logic [MAX_LEN-1:0] hist_q, hist_d;
  logic [LEN_W-1:0]   fill_q, fill_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               cfg_err_q, cfg_err_d;

  logic               cfg_legal;
  logic               accept;
  logic [MAX_LEN-1:0] hist_shift;
  logic [LEN_W-1:0]   fill_inc;
  logic [MAX_LEN-1:0] len_mask;
  logic               is_match;

  assign cfg_legal  = (cfg_len_i != '0) && (cfg_len_i <= LEN_W'(MAX_LEN));
  assign accept     = in_valid_i && !cfg_load_i && (state_q != UNCFG);
  assign hist_shift = {hist_q[MAX_LEN-2:0], in_i};
  assign fill_inc   = fill_q + LEN_W'(1);

  // Only the low L bits of the history take part in the comparison.
  always_comb begin
    len_mask = '0;
    for (int i = 0; i < MAX_LEN; i++) begin
      len_mask[i] = (i < int'(len_q));
    end
  end

  assign is_match = accept && (fill_inc >= len_q) &&
                    ((hist_shift & len_mask) == (pattern_q & len_mask));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= UNCFG;
      pattern_q <= '0;
      len_q     <= LEN_W'(1);
      overlap_q <= 1'b0;
      hist_q    <= '0;
      fill_q    <= '0;
      count_q   <= '0;
      cfg_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pattern_q <= pattern_d;
      len_q     <= len_d;
      overlap_q <= overlap_d;
      hist_q    <= hist_d;
      fill_q    <= fill_d;
      count_q   <= count_d;
      cfg_err_q <= cfg_err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    pattern_d = pattern_q;
    len_d     = len_q;
    overlap_d = overlap_q;
    hist_d    = hist_q;
    fill_d    = fill_q;
    count_d   = count_q;
    cfg_err_d = 1'b0;

    if (cfg_load_i) begin
      if (cfg_legal) begin
        pattern_d = cfg_pattern_i;
        len_d     = cfg_len_i;
        overlap_d = cfg_overlap_i;
        hist_d    = '0;
        fill_d    = '0;
        state_d   = SEARCH;
      end else begin
        // A rejected load keeps the configuration; it only costs this cycle's bit.
        cfg_err_d = 1'b1;
        if (state_q != UNCFG) begin
          state_d = SEARCH;
        end
      end
    end else if (state_q != UNCFG) begin
      state_d = is_match ? MATCH : SEARCH;
      if (accept) begin
        hist_d = hist_shift;
        if (is_match && !overlap_q) begin
          fill_d = '0;
        end else begin
          fill_d = (fill_inc > len_q) ? len_q : fill_inc;
        end
      end
    end

    if (cnt_clr_i) begin
      count_d = '0;
    end else if (is_match && (count_q != '1)) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  assign out_o         = (state_q == MATCH);
  assign match_count_o = count_q;
  assign state_o       = state_q;
  assign cfg_err_o     = cfg_err_q;

endmodule

// File: tb/tb_moore_seq_detector.sv
// Bench for moore_seq_detector: directed scenarios plus a random stream, all checked
// against a queue-based reference model of the detector's matching rules.
module tb_moore_seq_detector;

  localparam int MAX_LEN = 8;
  localparam int CNT_W   = 4;
  localparam int LEN_W   = $clog2(MAX_LEN) + 1;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic               clk = 1'b0;
  logic               rst;
  logic               cfgLoad;
  logic [MAX_LEN-1:0] cfgPattern;
  logic [LEN_W-1:0]   cfgLen;
  logic               cfgOverlap;
  logic               inValid;
  logic               inBit;
  logic               cntClr;
  logic               matchOut;
  logic [CNT_W-1:0]   matchCount;
  logic [1:0]         stateObs;
  logic               cfgErr;

  int vectors;
  int miscompares;

  // Reference model: queue of accepted bits plus a count of fresh bits since the last reset point.
  int                 mState;
  int                 mCount;
  int                 mErr;
  int                 mLen;
  bit                 mOvl;
  int                 mFresh;
  logic [MAX_LEN-1:0] mPat;
  bit                 mHist[$];

  always #5 clk = ~clk;

  moore_seq_detector #(
    .MAX_LEN(MAX_LEN),
    .CNT_W  (CNT_W)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .cfg_load_i   (cfgLoad),
    .cfg_pattern_i(cfgPattern),
    .cfg_len_i    (cfgLen),
    .cfg_overlap_i(cfgOverlap),
    .in_valid_i   (inValid),
    .in_i         (inBit),
    .cnt_clr_i    (cntClr),
    .out_o        (matchOut),
    .match_count_o(matchCount),
    .state_o      (stateObs),
    .cfg_err_o    (cfgErr)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic checkAll(input string tag);
    checkOutput({tag, "_out"},   32'(matchOut),   (mState == 2) ? 32'd1 : 32'd0);
    checkOutput({tag, "_state"}, 32'(stateObs),   32'(mState));
    checkOutput({tag, "_count"}, 32'(matchCount), 32'(mCount));
    checkOutput({tag, "_err"},   32'(cfgErr),     32'(mErr));
  endtask

  task automatic modelReset();
    mState = 0;
    mCount = 0;
    mErr   = 0;
    mLen   = 1;
    mOvl   = 1'b0;
    mFresh = 0;
    mPat   = '0;
    mHist.delete();
  endtask

  // The newest bit lines up with pattern bit 0, the oldest of the last L with bit L-1.
  function automatic bit tailMatches();
    for (int j = 0; j < mLen; j++) begin
      if (mHist[mHist.size() - 1 - j] != mPat[j]) return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic modelClock();
    bit lenOk;
    bit hit;
    lenOk = (int'(cfgLen) >= 1) && (int'(cfgLen) <= MAX_LEN);
    hit   = 1'b0;
    if (cfgLoad && lenOk) begin
      mPat   = cfgPattern;
      mLen   = int'(cfgLen);
      mOvl   = cfgOverlap;
      mFresh = 0;
      mHist.delete();
      mState = 1;
    end else if (mState != 0) begin
      if (inValid && !cfgLoad) begin
        mHist.push_back(inBit);
        if (mHist.size() > MAX_LEN) void'(mHist.pop_front());
        mFresh++;
        if (mFresh >= mLen && tailMatches()) begin
          hit = 1'b1;
          if (!mOvl) mFresh = 0;
        end
      end
      mState = hit ? 2 : 1;
    end
    mErr = (cfgLoad && !lenOk) ? 1 : 0;
    if (cntClr) mCount = 0;
    else if (hit && mCount < CNT_MAX) mCount++;
  endtask

  task automatic applyStimulus(input string tag, input bit load, input logic [MAX_LEN-1:0] pat,
                               input logic [LEN_W-1:0] len, input bit ovl, input bit valid,
                               input bit b, input bit clr);
    cfgLoad    = load;
    cfgPattern = pat;
    cfgLen     = len;
    cfgOverlap = ovl;
    inValid    = valid;
    inBit      = b;
    cntClr     = clr;
    @(posedge clk);
    modelClock();
    #1;
    checkAll(tag);
  endtask

  task automatic sendBits(input string tag, input logic [15:0] bits, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      applyStimulus(tag, 1'b0, '0, '0, 1'b0, 1'b1, bits[i], 1'b0);
    end
  endtask

  task automatic idle(input string tag, input bit clr);
    applyStimulus(tag, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0, clr);
  endtask

  task automatic load(input string tag, input logic [MAX_LEN-1:0] pat, input logic [LEN_W-1:0] len, input bit ovl);
    applyStimulus(tag, 1'b1, pat, len, ovl, 1'b1, 1'b1, 1'b0);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst         = 1'b1;
    cfgLoad     = 1'b0;
    cfgPattern  = '0;
    cfgLen      = '0;
    cfgOverlap  = 1'b0;
    inValid     = 1'b0;
    inBit       = 1'b0;
    cntClr      = 1'b0;
    modelReset();
    repeat (2) @(posedge clk);
    #1;
    checkAll("reset");
    rst = 1'b0;

    // Unconfigured detector ignores the stream and rejects bad lengths.
    sendBits("uncfg", 16'b1111, 4);
    load("err_len0", 8'hA5, LEN_W'(0), 1'b1);
    checkOutput("err_len0_pulse", 32'(cfgErr), 32'd1);
    idle("err_len0_after", 1'b0);
    checkOutput("err_len0_clear", 32'(cfgErr), 32'd0);
    load("err_len9", 8'h5A, LEN_W'(MAX_LEN + 1), 1'b0);
    checkOutput("err_len9_pulse", 32'(cfgErr), 32'd1);
    checkOutput("err_len9_state", 32'(stateObs), 32'd0);
    sendBits("uncfg2", 16'b1010, 4);

    // "10", overlapping
    load("t10_load", 8'b10, LEN_W'(2), 1'b1);
    sendBits("t10", 16'b110010, 6);
    checkOutput("t10_total", 32'(matchCount), 32'd2);

    // "11", overlapping then non-overlapping
    idle("clr_a", 1'b1);
    load("t11o_load", 8'b11, LEN_W'(2), 1'b1);
    sendBits("t11o", 16'b1111, 4);
    checkOutput("t11o_total", 32'(matchCount), 32'd3);
    idle("clr_b", 1'b1);
    load("t11n_load", 8'b11, LEN_W'(2), 1'b0);
    sendBits("t11n", 16'b1111, 4);
    checkOutput("t11n_total", 32'(matchCount), 32'd2);

    // "1011" with a three-cycle valid gap between bits 2 and 3
    idle("clr_c", 1'b1);
    load("t1011_load", 8'b1011, LEN_W'(4), 1'b0);
    sendBits("t1011_a", 16'b10, 2);
    for (int i = 0; i < 3; i++) begin
      idle("t1011_gap", 1'b0);
      checkOutput("t1011_gap_out", 32'(matchOut), 32'd0);
    end
    sendBits("t1011_b", 16'b11, 2);
    checkOutput("t1011_hit", 32'(matchOut), 32'd1);
    checkOutput("t1011_total", 32'(matchCount), 32'd1);

    // A rejected load while searching keeps the old pattern alive.
    idle("t1011_idle", 1'b0);
    load("err_search", 8'h00, LEN_W'(0), 1'b1);
    checkOutput("err_search_state", 32'(stateObs), 32'd1);
    sendBits("t1011_c", 16'b1011, 4);
    checkOutput("t1011_total2", 32'(matchCount), 32'd2);

    // Single-bit pattern drives the counter into saturation; clear wins over a match.
    idle("clr_d", 1'b1);
    load("sat_load", 8'b1, LEN_W'(1), 1'b0);
    sendBits("sat_a", 16'hFFFF, CNT_MAX);
    checkOutput("sat_full", 32'(matchCount), 32'(CNT_MAX));
    sendBits("sat_b", 16'hFFFF, 5);
    checkOutput("sat_hold", 32'(matchCount), 32'(CNT_MAX));
    applyStimulus("sat_clr", 1'b0, '0, '0, 1'b0, 1'b1, 1'b1, 1'b1);
    checkOutput("sat_clr_out", 32'(matchOut), 32'd1);
    checkOutput("sat_clr_count", 32'(matchCount), 32'd0);

    // Random stream with occasional legal reconfiguration and counter clears.
    for (int i = 0; i < 400; i++) begin
      bit rLoad;
      logic [LEN_W-1:0] rLen;
      rLoad = ($urandom_range(0, 39) == 0);
      rLen  = ($urandom_range(0, 3) == 0) ? LEN_W'($urandom_range(1, MAX_LEN))
                                          : LEN_W'($urandom_range(1, 4));
      applyStimulus("rand", rLoad, MAX_LEN'($urandom), rLen, 1'($urandom_range(0, 1)),
                    ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                    ($urandom_range(0, 29) == 0));
    end

    // Asynchronous reset while in MATCH.
    load("arst_load", 8'b1, LEN_W'(1), 1'b1);
    sendBits("arst_hit", 16'b1, 1);
    checkOutput("arst_pre_state", 32'(stateObs), 32'd2);
    rst = 1'b1;
    #1;
    modelReset();
    checkAll("arst_now");
    checkOutput("arst_out", 32'(matchOut), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    sendBits("arst_ignored", 16'b1111, 4);
    checkOutput("arst_ignored_count", 32'(matchCount), 32'd0);
    load("arst_reload", 8'b1, LEN_W'(1), 1'b1);
    sendBits("arst_again", 16'b1, 1);
    checkOutput("arst_again_out", 32'(matchOut), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
